// File: rtl/miriscv_alu_arbiter.sv
// miriscv_alu_arbiter: two-client arbiter and sequencer in front of one shared ALU.
// A granted request's operator and operands are latched, the ALU works only from
// those registers, and the result is held until the owning client accepts it.
// Optional feature: define MIRISCV_ALU_ARB_RR_EN for round-robin arbitration;
// when it is undefined, client 0 has fixed priority on contention.

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`define ALU_ADD  5'b00000
`define ALU_SUB  5'b01000
`define ALU_XOR  5'b00100
`define ALU_OR   5'b00110
`define ALU_AND  5'b00111
`define ALU_SRA  5'b01101
`define ALU_SRL  5'b00101
`define ALU_SLL  5'b00001
`define ALU_LTS  5'b11100
`define ALU_LTU  5'b11110
`define ALU_GES  5'b11101
`define ALU_GEU  5'b11111
`define ALU_EQ   5'b11000
`define ALU_NE   5'b11001
`define ALU_SLTS 5'b00010
`define ALU_SLTU 5'b00011
`endif

// Shared miriscv ALU: arithmetic, logic, shifts and comparisons.
module miriscv_alu (
    input  logic [`ALU_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]              operand_a_i,
    input  logic [31:0]              operand_b_i,
    output logic [31:0]              result_o,
    output logic                     comparison_result_o
);
    logic [4:0] shamt;
    logic       lts;
    logic       ltu;
    logic       eq;

    assign shamt = operand_b_i[4:0];
    assign lts   = $signed(operand_a_i) < $signed(operand_b_i);
    assign ltu   = operand_a_i < operand_b_i;
    assign eq    = operand_a_i == operand_b_i;

    // Decode the operator; branch comparisons also mirror the flag onto bit 0 of the result.
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        result_o            = 32'd0;
        comparison_result_o = 1'b0;
        case (operator_i)
            `ALU_ADD:  result_o = operand_a_i + operand_b_i;
            `ALU_SUB:  result_o = operand_a_i - operand_b_i;
            `ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
            `ALU_OR:   result_o = operand_a_i | operand_b_i;
            `ALU_AND:  result_o = operand_a_i & operand_b_i;
            `ALU_SLL:  result_o = operand_a_i << shamt;
            `ALU_SRL:  result_o = operand_a_i >> shamt;
            `ALU_SRA:  result_o = $unsigned($signed(operand_a_i) >>> shamt);
            `ALU_SLTS: result_o = {31'd0, lts};
            `ALU_SLTU: result_o = {31'd0, ltu};
            `ALU_LTS:  begin comparison_result_o = lts;  result_o = {31'd0, lts};  end
            `ALU_LTU:  begin comparison_result_o = ltu;  result_o = {31'd0, ltu};  end
            `ALU_GES:  begin comparison_result_o = ~lts; result_o = {31'd0, ~lts}; end
            `ALU_GEU:  begin comparison_result_o = ~ltu; result_o = {31'd0, ~ltu}; end
            `ALU_EQ:   begin comparison_result_o = eq;   result_o = {31'd0, eq};   end
            `ALU_NE:   begin comparison_result_o = ~eq;  result_o = {31'd0, ~eq};  end
            default:   ;
        endcase
    end
endmodule

// Arbiter / sequencer owning the single ALU instance.
module miriscv_alu_arbiter (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     req0_valid_i,
    output logic                     req0_ready_o,
    input  logic [`ALU_OP_WIDTH-1:0] req0_op_i,
    input  logic [31:0]              req0_a_i,
    input  logic [31:0]              req0_b_i,
    input  logic                     req1_valid_i,
    output logic                     req1_ready_o,
    input  logic [`ALU_OP_WIDTH-1:0] req1_op_i,
    input  logic [31:0]              req1_a_i,
    input  logic [31:0]              req1_b_i,
    output logic                     rsp0_valid_o,
    input  logic                     rsp0_ready_i,
    output logic                     rsp1_valid_o,
    input  logic                     rsp1_ready_i,
    output logic [31:0]              rsp_result_o,
    output logic                     rsp_cmp_o,
    output logic                     busy_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic [`ALU_OP_WIDTH-1:0]  op_q, op_d;
    logic [31:0]               a_q, a_d;
    logic [31:0]               b_q, b_d;
    logic                      owner_q, owner_d;
    logic                      last_grant_q, last_grant_d;
    logic                      prefer1;
    logic                      gnt0;
    logic                      gnt1;

    // Contention policy: which client wins when both are valid.
`ifdef MIRISCV_ALU_ARB_RR_EN
    assign prefer1 = ~last_grant_q;
`else
    assign prefer1 = 1'b0;
`endif

    assign gnt0 = req0_valid_i & (~req1_valid_i | ~prefer1);
    assign gnt1 = req1_valid_i & (~req0_valid_i | prefer1);

    // Next-state, register loads and handshake outputs; rsp ready never feeds req ready.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        busy_o       = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready_o = gnt0;
                req1_ready_o = gnt1;
                if (gnt0) begin
                    op_d    = req0_op_i;
                    a_d     = req0_a_i;
                    b_d     = req0_b_i;
                    owner_d = 1'b0;
                    state_d = BUSY;
                end else if (gnt1) begin
                    op_d    = req1_op_i;
                    a_d     = req1_a_i;
                    b_d     = req1_b_i;
                    owner_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy_o       = 1'b1;
                rsp0_valid_o = ~owner_q;
                rsp1_valid_o = owner_q;
                if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and operand registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the operand registers are reset too, so the shared result bus reads 0 out of reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= IDLE;
            op_q         <= `ALU_ADD;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    miriscv_alu u_alu (
        .operator_i          (op_q),
        .operand_a_i         (a_q),
        .operand_b_i         (b_q),
        .result_o            (rsp_result_o),
        .comparison_result_o (rsp_cmp_o)
    );
endmodule
